// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues hold-until-ready reads to instruction
// memory and presents fetched words to decode, absorbing back-pressure in a skid register.
module instr_fetch #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr
);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, FULL} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [31:0]     out_instr_q, out_instr_d;
    logic            sk_valid_q, sk_valid_d;
    logic [XLEN-1:0] sk_pc_q, sk_pc_d;
    logic [31:0]     sk_instr_q, sk_instr_d;

    logic            consumed;
    logic [XLEN-1:0] redir_target;
    logic [XLEN-1:0] pc_inc;

    assign consumed     = out_valid_q && !stall;
    assign redir_target = redirect_pc & ~XLEN'(3);
    assign pc_inc       = pc_q + XLEN'(4);

    // Request and address depend on registered state only, so stall or redirect
    // can never disturb an access that is already outstanding.
    assign imem_req  = (state_q == REQ) || (state_q == DRAIN);
    assign imem_addr = pc_q;

    assign if_valid = out_valid_q;
    assign if_pc    = out_pc_q;
    assign if_instr = out_instr_q;

    always_comb begin
        // NOTE: every next-state value defaults to its register first, so no path
        // through the case below can leave a signal unassigned and infer a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        redir_pc_d  = redir_pc_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        sk_valid_d  = sk_valid_q;
        sk_pc_d     = sk_pc_q;
        sk_instr_d  = sk_instr_q;

        if (consumed) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect_valid) begin
                    pc_d = redir_target;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    if (imem_ready) begin
                        pc_d = redir_target;
                    end else begin
                        redir_pc_d = redir_target;
                        state_d    = DRAIN;
                    end
                end else if (imem_ready) begin
                    pc_d = pc_inc;
                    if (!out_valid_q || !stall) begin
                        out_valid_d = 1'b1;
                        out_pc_d    = pc_q;
                        out_instr_d = imem_rdata;
                    end else begin
                        sk_valid_d = 1'b1;
                        sk_pc_d    = pc_q;
                        sk_instr_d = imem_rdata;
                        state_d    = FULL;
                    end
                end
            end
            DRAIN: begin
                // The stale access must still complete; the last redirect seen wins.
                if (redirect_valid) begin
                    redir_pc_d = redir_target;
                end
                if (imem_ready) begin
                    pc_d    = redirect_valid ? redir_target : redir_pc_q;
                    state_d = REQ;
                end
            end
            FULL: begin
                if (redirect_valid) begin
                    pc_d    = redir_target;
                    state_d = REQ;
                end else if (consumed) begin
                    out_valid_d = sk_valid_q;
                    out_pc_d    = sk_pc_q;
                    out_instr_d = sk_instr_q;
                    sk_valid_d  = 1'b0;
                    state_d     = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        // A redirect flushes both holding registers, beating stall and any load above.
        if (redirect_valid) begin
            out_valid_d = 1'b0;
            sk_valid_d  = 1'b0;
        end
    end

    // NOTE: non-blocking assignments make every register take its value from the
    // same pre-edge state, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            redir_pc_q  <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
            sk_valid_q  <= 1'b0;
            sk_pc_q     <= '0;
            sk_instr_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            redir_pc_q  <= redir_pc_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            sk_valid_q  <= sk_valid_d;
            sk_pc_q     <= sk_pc_d;
            sk_instr_q  <= sk_instr_d;
        end
    end

endmodule
